// File: rtl/approx_adder_err_monitor_if.sv
// ============================================================================
// Module   : approx_adder_err_monitor_if
// Brief    : Operand/result valid-ready channel into the approximate-adder monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface approx_adder_err_monitor_if #(
  parameter int OP_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_a;
  logic [OP_W-1:0] in_b;
  logic [OP_W:0]   in_approx;

  modport master (output in_valid, in_a, in_b, in_approx, input in_ready);
  modport slave  (input in_valid, in_a, in_b, in_approx, output in_ready);
endinterface

`default_nettype wire

// File: rtl/approx_adder_err_monitor.sv
// ============================================================================
// Module   : approx_adder_err_monitor
// Brief    : Recomputes exact sums of approximate-adder triples and accumulates
//            error-rate / error-distance statistics over a programmed run.
// Revision : 1.0
// ============================================================================
`default_nettype none

module approx_adder_err_monitor #(
  parameter int OP_W  = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  start,
  input  wire logic [CNT_W-1:0]      num_samples,
  approx_adder_err_monitor_if.slave  in_if,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           samples_seen,
  output logic [CNT_W-1:0]           err_count,
  output logic [ACC_W-1:0]           sum_ed,
  output logic [OP_W:0]              max_ed,
  output logic [OP_W-1:0]            worst_a,
  output logic [OP_W-1:0]            worst_b
);

  localparam int c_SUM_W = ((ACC_W > OP_W + 1) ? ACC_W : OP_W + 1) + 1;
  localparam logic [c_SUM_W-1:0] c_ACC_MAX = c_SUM_W'({ACC_W{1'b1}});
  localparam logic [CNT_W-1:0]   c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0] r_num, r_seen, r_err;
  logic [ACC_W-1:0] r_sum;
  logic [OP_W:0]    r_max;
  logic [OP_W-1:0]  r_wa, r_wb;

  logic             r_p0_vld;
  logic [OP_W-1:0]  r_p0_a, r_p0_b;
  logic [OP_W:0]    r_p0_approx;
  logic             r_s1_vld;
  logic [OP_W:0]    r_s1_ed;
  logic [OP_W-1:0]  r_s1_a, r_s1_b;

  logic               w_ready, w_xfer, w_last, w_start_ok;
  logic [OP_W:0]      w_exact, w_ed;
  logic [c_SUM_W-1:0] w_sum_wide;
  logic [ACC_W-1:0]   w_sum_sat;

  assign w_ready    = (r_state == ST_RUN) && (r_seen < r_num);
  assign w_xfer     = in_if.in_valid && w_ready;
  assign w_last     = w_xfer && ((r_seen + c_CNT_ONE) == r_num);
  assign w_start_ok = start && (r_state == ST_IDLE);

  assign w_exact = {1'b0, r_p0_a} + {1'b0, r_p0_b};
  assign w_ed    = (w_exact >= r_p0_approx) ? (w_exact - r_p0_approx)
                                            : (r_p0_approx - w_exact);

  // Widen before adding so both a narrow ACC_W and the ed term fit without wrap.
  assign w_sum_wide = c_SUM_W'(r_sum) + c_SUM_W'(r_s1_ed);
  assign w_sum_sat  = (w_sum_wide > c_ACC_MAX) ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // DRAIN leaves once stage 0 is empty: the final stats land on that same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = (num_samples == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_p0_vld) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0_vld    <= 1'b0;
      r_p0_a      <= '0;
      r_p0_b      <= '0;
      r_p0_approx <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_ed     <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
    end else begin
      r_p0_vld <= w_xfer;
      if (w_xfer) begin
        r_p0_a      <= in_if.in_a;
        r_p0_b      <= in_if.in_b;
        r_p0_approx <= in_if.in_approx;
      end
      r_s1_vld <= r_p0_vld;
      if (r_p0_vld) begin
        r_s1_ed <= w_ed;
        r_s1_a  <= r_p0_a;
        r_s1_b  <= r_p0_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num  <= '0;
      r_seen <= '0;
      r_err  <= '0;
      r_sum  <= '0;
      r_max  <= '0;
      r_wa   <= '0;
      r_wb   <= '0;
    end else if (w_start_ok) begin
      r_num  <= num_samples;
      r_seen <= '0;
      r_err  <= '0;
      r_sum  <= '0;
      r_max  <= '0;
      r_wa   <= '0;
      r_wb   <= '0;
    end else begin
      if (w_xfer) r_seen <= r_seen + c_CNT_ONE;
      if (r_s1_vld) begin
        if (r_s1_ed != '0) r_err <= r_err + c_CNT_ONE;
        r_sum <= w_sum_sat;
        // Strict compare: ties keep the operands of the first occurrence.
        if (r_s1_ed > r_max) begin
          r_max <= r_s1_ed;
          r_wa  <= r_s1_a;
          r_wb  <= r_s1_b;
        end
      end
    end
  end

  assign in_if.in_ready = w_ready;
  assign busy           = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done           = (r_state == ST_DONE);
  assign samples_seen   = r_seen;
  assign err_count      = r_err;
  assign sum_ed         = r_sum;
  assign max_ed         = r_max;
  assign worst_a        = r_wa;
  assign worst_b        = r_wb;

endmodule

`default_nettype wire

// File: tb/tb_approx_adder_err_monitor.sv
// ============================================================================
// Module   : tb_approx_adder_err_monitor
// Brief    : Scoreboard bench; a 48-bit and a 13-bit accumulator instance share stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_approx_adder_err_monitor;

  localparam int OP_W  = 16;
  localparam int CNT_W = 32;
  localparam int ACC_W = 48;
  localparam int ACC_S = 13;
  localparam logic [63:0] c_SAT_S = 64'h1FFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;

  always #5 clk = ~clk;

  approx_adder_err_monitor_if #(.OP_W(OP_W)) ifm ();
  approx_adder_err_monitor_if #(.OP_W(OP_W)) ifs ();

  assign ifs.in_valid  = ifm.in_valid;
  assign ifs.in_a      = ifm.in_a;
  assign ifs.in_b      = ifm.in_b;
  assign ifs.in_approx = ifm.in_approx;

  logic             busy, done, busy_s, done_s;
  logic [CNT_W-1:0] seen, errc, seen_s, errc_s;
  logic [ACC_W-1:0] sum;
  logic [ACC_S-1:0] sum_s;
  logic [OP_W:0]    maxe, maxe_s;
  logic [OP_W-1:0]  wa, wb, wa_s, wb_s;

  approx_adder_err_monitor #(.OP_W(OP_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .in_if(ifm),
    .busy(busy), .done(done), .samples_seen(seen), .err_count(errc), .sum_ed(sum),
    .max_ed(maxe), .worst_a(wa), .worst_b(wb));

  approx_adder_err_monitor #(.OP_W(OP_W), .CNT_W(CNT_W), .ACC_W(ACC_S)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .in_if(ifs),
    .busy(busy_s), .done(done_s), .samples_seen(seen_s), .err_count(errc_s), .sum_ed(sum_s),
    .max_ed(maxe_s), .worst_a(wa_s), .worst_b(wb_s));

  typedef struct {
    logic [CNT_W-1:0] seen;
    logic [CNT_W-1:0] err;
    logic [63:0]      sum;
    logic [OP_W:0]    max;
    logic [OP_W-1:0]  wa;
    logic [OP_W-1:0]  wb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int dones  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int s, input int e, input logic [63:0] su, input logic [OP_W:0] m,
                      input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    exp_t x;
    x.seen = CNT_W'(s); x.err = CNT_W'(e); x.sum = su; x.max = m; x.wa = a; x.wb = b;
    q.push_back(x);
  endtask

  // Scoreboard monitor: each done pulse retires one expected run.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (done || done_s)) begin
      chk("done_pair", done_s, done);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending run");
      end else begin
        e = q.pop_front();
        dones++;
        chk("samples_seen", seen, e.seen);
        chk("err_count", errc, e.err);
        chk("sum_ed", sum, e.sum);
        chk("max_ed", maxe, e.max);
        chk("worst_a", wa, e.wa);
        chk("worst_b", wb, e.wb);
        chk("s_samples_seen", seen_s, e.seen);
        chk("s_err_count", errc_s, e.err);
        chk("s_sum_ed_sat", sum_s, (e.sum > c_SAT_S) ? c_SAT_S : e.sum);
        chk("s_max_ed", maxe_s, e.max);
        chk("s_worst_a", wa_s, e.wa);
        chk("s_worst_b", wb_s, e.wb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n, output int scyc);
    start = 1'b1;
    num_samples = CNT_W'(n);
    tick();
    scyc = cyc;
    start = 1'b0;
  endtask

  task automatic send(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                      input logic [OP_W:0] ap, output int acc);
    bit ok;
    int g;
    ok = 1'b0;
    g = 0;
    ifm.in_valid = 1'b1;
    ifm.in_a = a;
    ifm.in_b = b;
    ifm.in_approx = ap;
    while (!ok && g < 50) begin
      @(negedge clk);
      ok = ifm.in_ready;
      tick();
      g++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    acc = cyc;
    ifm.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int dcyc, output bit rdy_seen);
    int g;
    g = 0;
    rdy_seen = 1'b0;
    dcyc = -1;
    while (g < 100) begin
      @(negedge clk);
      if (ifm.in_ready) rdy_seen = 1'b1;
      if (done) begin
        dcyc = cyc;
        break;
      end
      g++;
    end
    if (dcyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected 1 within 100 cycles");
    end else begin
      @(negedge clk);
      chk("done_width", done, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_seen"}, seen, 0);
    chk({tag, "_err"}, errc, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_max"}, maxe, 0);
    chk({tag, "_wab"}, {wa, wb}, 0);
    chk({tag, "_busy_done_rdy"}, {busy, done, ifm.in_ready}, 0);
  endtask

  initial begin : drv
    int s, acc, dc;
    bit rdy;
    logic [OP_W-1:0] ra, rb;
    ifm.in_valid = 1'b0;
    ifm.in_a = '0;
    ifm.in_b = '0;
    ifm.in_approx = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Exact adder model: no errors expected; a stray start mid-run must be ignored.
    push(1000, 0, 0, 0, 0, 0);
    start_run(1000, s);
    for (int i = 0; i < 1000; i++) begin
      ra = OP_W'($urandom);
      rb = OP_W'($urandom);
      send(ra, rb, {1'b0, ra} + {1'b0, rb}, acc);
      if (i % 7 == 0) tick();
      if (i == 500) begin
        start = 1'b1;
        num_samples = 3;
        tick();
        start = 1'b0;
      end
    end
    wait_done(dc, rdy);

    // Single erroneous triple; done visible two edges after the accept edge.
    push(1, 1, 4096, 17'h01000, 16'h0FFF, 16'h0001);
    start_run(1, s);
    send(16'h0FFF, 16'h0001, 17'h00000, acc);
    wait_done(dc, rdy);
    chk("latency_one", 64'(dc - acc), 64'd2);

    // Truncated result, tie on max_ed, approx above exact, and a stall gap.
    push(5, 4, 16395, 17'h01FFE, 16'hFFFF, 16'hFFFF);
    start_run(5, s);
    send(16'hFFFF, 16'hFFFF, 17'h1E000, acc);
    send(16'h1FFE, 16'h0000, 17'h00000, acc);
    tick();
    tick();
    send(16'h0100, 16'h0001, 17'h00100, acc);
    send(16'h0005, 16'h0007, 17'h0000C, acc);
    send(16'h0001, 16'h0001, 17'h00010, acc);
    wait_done(dc, rdy);

    // Back-to-back; max_ed grows to the carry-out weight and moves worst operands.
    push(3, 2, 65539, 17'h10000, 16'h0000, 16'h0000);
    start_run(3, s);
    send(16'h0002, 16'h0001, 17'h00000, acc);
    send(16'h0000, 16'h0000, 17'h10000, acc);
    send(16'hFFFF, 16'h0001, 17'h10000, acc);
    wait_done(dc, rdy);

    // Empty run: done right after the start edge, never ready.
    push(0, 0, 0, 0, 0, 0);
    start_run(0, s);
    wait_done(dc, rdy);
    chk("empty_latency", 64'(dc - s), 64'd0);
    chk("empty_ready_seen", rdy, 1'b0);

    // Abort half way with reset, then a clean 10-sample pass.
    start_run(10, s);
    for (int i = 0; i < 5; i++) begin
      send(OP_W'(i), OP_W'(i), 17'(2 * i), acc);
    end
    rst_n = 1'b0;
    #2;
    chk_idle("abort");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push(10, 10, 10, 17'h00001, 16'h0000, 16'h0000);
    start_run(10, s);
    for (int i = 0; i < 10; i++) begin
      send(OP_W'(i), OP_W'(i), 17'(2 * i + 1), acc);
    end
    wait_done(dc, rdy);

    repeat (3) tick();
    chk("done_count", 64'(dones), 64'd6);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
